// File: rtl/clkdiv.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv
// Brief    : Parameterised divider producing a registered square wave of
//            ~F1 Hz from clk (F0 Hz), plus a one-cycle wrap strobe.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv #(
  parameter int F0 = 50_000_000,
  parameter int F1 = 9_600
) (
  input  logic clk,
  input  logic rst_n,
  output logic out,
  output logic tick
);

  // Guarded so an illegal F1 reaches the check below instead of dividing by 0.
  localparam int DIV  = (F1 > 0) ? (F0 + F1 / 2) / F1 : 2;
  localparam int LOW  = DIV - DIV / 2;
  localparam int HIGH = DIV / 2;
  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_LOW  = CW'(LOW);

  generate
    if (F1 <= 0 || DIV < 2) begin : g_param_check
      $error("clkdiv: illegal parameters F0=%0d F1=%0d (need F1 > 0 and DIV >= 2)", F0, F1);
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic          r_tick;
  logic [CW-1:0] w_cnt_next;
  logic          w_wrap;

  always_comb begin
    w_wrap     = (r_cnt == C_LAST);
    w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
  end

  // out is decoded from the next count so it changes on the same edge as cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_out  <= (w_cnt_next >= C_LOW);
      r_tick <= w_wrap;
    end
  end

  assign out  = r_out;
  assign tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkdiv
// Brief    : Scoreboard bench for clkdiv: four instances share clk/rst_n,
//            randomised asynchronous resets, per-cycle model comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int NI = 4;

  typedef struct {
    logic [NI-1:0] o;
    logic [NI-1:0] t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] dout;
  logic [NI-1:0] dtick;

  int   checks = 0;
  int   passes = 0;
  int   n      = 0;
  exp_t q[$];

  int f0s[NI] = '{10, 50_000_000, 50_000_000, 50_000_000};
  int f1s[NI] = '{2, 115_200, 38_400, 9_600};

  clkdiv #(.F0(10),         .F1(2))       u_small (.clk(clk), .rst_n(rst_n), .out(dout[0]), .tick(dtick[0]));
  clkdiv #(.F0(50_000_000), .F1(115_200)) u_fast  (.clk(clk), .rst_n(rst_n), .out(dout[1]), .tick(dtick[1]));
  clkdiv #(.F0(50_000_000), .F1(38_400))  u_mid   (.clk(clk), .rst_n(rst_n), .out(dout[2]), .tick(dtick[2]));
  clkdiv #(.F0(50_000_000), .F1(9_600))   u_slow  (.clk(clk), .rst_n(rst_n), .out(dout[3]), .tick(dtick[3]));

  always #5 clk = ~clk;

  function automatic int div_of(input int i);
    return (f0s[i] + f1s[i] / 2) / f1s[i];
  endfunction

  // n = rising edges since reset release; out is high in the last DIV/2 slots.
  function automatic logic exp_out(input int i, input int edges);
    int d;
    d = div_of(i);
    return ((edges % d) >= (d - d / 2));
  endfunction

  function automatic logic exp_tick(input int i, input int edges);
    return (edges != 0) && ((edges % div_of(i)) == 0);
  endfunction

  task automatic check(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s inst=%0d n=%0d got %b expected %b", name, i, n, act, exp);
  endtask

  // Reference model: one expectation per clk edge.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) n = 0;
    else        n++;
    for (int i = 0; i < NI; i++) begin
      e.o[i] = exp_out(i, n);
      e.t[i] = exp_tick(i, n);
    end
    q.push_back(e);
  end

  // Monitor: compare DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < NI; i++) begin
        check("out",  i, dout[i],  e.o[i]);
        check("tick", i, dtick[i], e.t[i]);
      end
    end
  end

  // Reset is asserted between the falling and rising clk edges and must
  // clear the outputs without any clk edge.
  task automatic async_reset(input int hold);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("async_rst_out",  i, dout[i],  1'b0);
      check("async_rst_tick", i, dtick[i], 1'b0);
    end
    repeat (hold) @(posedge clk);
    #7 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      check("reset_out",  i, dout[i],  1'b0);
      check("reset_tick", i, dtick[i], 1'b0);
    end
    repeat (3) @(posedge clk);
    #7 rst_n = 1'b1;

    repeat (7500) @(posedge clk);

    // Land inside a high phase of the 115200 instance, then reset.
    while (!exp_out(1, n)) @(posedge clk);
    #7;
    check("pre_rst_high", 1, dout[1], 1'b1);
    async_reset(2);

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 3000)) @(posedge clk);
      #7;
      async_reset(int'($urandom_range(1, 5)));
    end

    repeat (600) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
